sprite_mem_arbiter: RTL and testbench
=====================================

// Module: sprite_mem_arbiter
// PURPOSE
//  Shares the single port of a sprite SRAM (R, G or B plane) between two requesters:
//   - the pixel-fetch path, which reads during active video;
//   - a sprite loader, which writes new sprite data during blanking.
//  Sits between the VGA sprite pixel path and the sram instance; one arbiter per colour plane.
//  Display reads always win; the loader is granted only in blanking and is preempted instantly.
// PARAMETERS
//  ADDR_W  16     SRAM address width
//  DATA_W  8      SRAM data width (one colour channel)
//  DEPTH   40320  valid words; addresses >= DEPTH are out of range
// PORTS
//  clk        in   1       single clock, all logic rising-edge
//  rst_n      in   1       asynchronous active-low reset
//  blank      in   1       1 = VGA outside active video (loader window)
//  disp_req   in   1       display read request, one word per cycle
//  disp_addr  in   ADDR_W  display read address
//  disp_rvalid out 1       read data valid, exactly 1 cycle after accepted disp_req
//  disp_rdata out  DATA_W  read data; 0 when the request address was out of range
//  ld_req     in   1       loader wants the port; held high for a burst
//  ld_addr    in   ADDR_W  loader write address
//  ld_wdata   in   DATA_W  loader write data
//  ld_gnt     out  1       write accepted this cycle when ld_req & ld_gnt
//  ld_preempt out  1       1-cycle pulse: loader burst cut by display/blank end
//  ld_err     out  1       sticky: a granted write had ld_addr >= DEPTH
//  mem_addr   out  ADDR_W  to SRAM address
//  mem_wren   out  1       to SRAM write enable
//  mem_wdata  out  DATA_W  to SRAM write data
//  mem_rdata  in   DATA_W  from SRAM, registered read (1-cycle latency)
// BEHAVIOUR
//  Reset: state=IDLE; disp_rvalid, ld_gnt, ld_preempt, ld_err, mem_wren = 0; mem_addr, mem_wdata = 0.
//  FSM states: IDLE, LOAD.
//   IDLE -> LOAD : ld_req & blank & !disp_req at a rising edge.
//   LOAD -> IDLE : !ld_req (normal end, no pulse),
//                  or disp_req | !blank (preempt: ld_preempt=1 the following cycle).
//  Port mux (combinational):
//   - disp_req=1: mem_addr=disp_addr, mem_wren=0, ld_gnt=0, in any state.
//     The display gets the port the same cycle even if the FSM is in LOAD.
//   - else if state=LOAD & blank: ld_gnt=1, mem_addr=ld_addr, mem_wdata=ld_wdata,
//     mem_wren = ld_req & (ld_addr < DEPTH).
//   - else: mem_wren=0, ld_gnt=0, mem_addr holds its last value.
//  Read pipeline:
//   - disp_rvalid(t+1) = disp_req(t).
//   - disp_rdata(t+1) = (disp_addr(t) < DEPTH) ? mem_rdata : 0; the range flag is registered with the request.
//   - Back-to-back reads give full throughput.
//  Loader:
//   - One write per cycle while in LOAD with ld_req=1.
//   - First grant comes 1 cycle after ld_req rises (IDLE->LOAD edge).
//   - An out-of-range write is dropped (mem_wren=0) but still counts as accepted, and sets ld_err.
//   - ld_err clears only on reset.
//  Simultaneous disp_req & ld_req in IDLE: display served; FSM stays IDLE.
//  Preempted loader: must hold ld_addr/ld_wdata and re-request; the un-granted word is not written.
//  Address compare is unsigned, full ADDR_W width; no wrap-around.
//  Reset mid-burst: mem_wren drops asynchronously; a partial burst is not resumed.
// CONFIGURATION
//  SPRITE_ARB_STATS_EN defined:
//   - adds out ports wr_count[15:0] and preempt_count[15:0].
//   - wr_count: +1 per accepted in-range write; preempt_count: +1 per ld_preempt.
//   - both saturate at 16'hFFFF; both reset to 0.
//  Not defined: ports and counters absent; all other behaviour identical.
// TESTING
//  1 Reset: rst_n=0 mid-cycle -> all outputs 0 immediately; after release state=IDLE, ld_gnt=0.
//  2 Read: disp_req=1, addr=5, then addr=6 on consecutive cycles, SRAM word5=8'h3C, word6=8'hA1
//    -> disp_rvalid=1 for 2 cycles, disp_rdata=3C then A1.
//  3 Burst: blank=1, ld_req=1 for 4 words, addr 0..3, data 10..13 -> ld_gnt from 2nd cycle,
//    4 mem_wren pulses, readback gives 10..13.
//  4 Preempt: burst active, blank falls after 2 writes -> ld_gnt=0 that cycle, ld_preempt pulse,
//    only 2 words written.
//  5 Range: ld_addr=40320 granted -> mem_wren=0, ld_err=1 sticky.
//    disp_addr=40320 -> disp_rvalid=1, disp_rdata=0.
//  6 Conflict: disp_req & ld_req both high, blank=1, in IDLE -> display read served,
//    FSM stays IDLE, ld_gnt=0 until disp_req drops.
//    With SPRITE_ARB_STATS_EN, test 4 -> wr_count=2, preempt_count=1.

Source files
------------

// File: rtl/sprite_mem_arbiter_if.sv
// rtl/sprite_mem_arbiter_if.sv - display/loader/SRAM bus bundle for one sprite colour plane
interface sprite_mem_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
);
    logic              blank;
    logic              disp_req;
    logic [ADDR_W-1:0] disp_addr;
    logic              disp_rvalid;
    logic [DATA_W-1:0] disp_rdata;
    logic              ld_req;
    logic [ADDR_W-1:0] ld_addr;
    logic [DATA_W-1:0] ld_wdata;
    logic              ld_gnt;
    logic              ld_preempt;
    logic              ld_err;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_wren;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  blank, disp_req, disp_addr, ld_req, ld_addr, ld_wdata, mem_rdata,
        output disp_rvalid, disp_rdata, ld_gnt, ld_preempt, ld_err,
               mem_addr, mem_wren, mem_wdata
    );

    modport master (
        output blank, disp_req, disp_addr, ld_req, ld_addr, ld_wdata, mem_rdata,
        input  disp_rvalid, disp_rdata, ld_gnt, ld_preempt, ld_err,
               mem_addr, mem_wren, mem_wdata
    );
endinterface

// File: rtl/sprite_mem_arbiter.sv
// rtl/sprite_mem_arbiter.sv - display-priority SRAM port arbiter; SPRITE_ARB_STATS_EN adds write/preempt counters
module sprite_mem_arbiter #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 40320
) (
    input  logic                  clk,
    input  logic                  rst_n,
    sprite_mem_arbiter_if.slave   bus
`ifdef SPRITE_ARB_STATS_EN
    ,
    output logic [15:0]           wr_count,
    output logic [15:0]           preempt_count
`endif
);
    typedef enum logic {IDLE, LOAD} state_t;

    // One extra bit so DEPTH == 2**ADDR_W still compares correctly.
    localparam logic [ADDR_W:0] DEPTH_W = DEPTH[ADDR_W:0];

    state_t            state_q, state_d;
    logic              preempt_q, preempt_d;
    logic              err_q, err_d;
    logic              rvalid_q, rvalid_d;
    logic              rd_in_range_q, rd_in_range_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              gnt_c, wren_c, wr_acc_c, ld_in_range_c;
`ifdef SPRITE_ARB_STATS_EN
    logic [15:0]       wr_cnt_q, wr_cnt_d;
    logic [15:0]       pre_cnt_q, pre_cnt_d;
`endif

    always_comb begin
        ld_in_range_c = {1'b0, bus.ld_addr} < DEPTH_W;
        rd_in_range_d = {1'b0, bus.disp_addr} < DEPTH_W;
        rvalid_d      = bus.disp_req;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;
        gnt_c         = 1'b0;
        wren_c        = 1'b0;

        // The display takes the port in the same cycle, even mid-burst.
        if (bus.disp_req) begin
            mem_addr_d = bus.disp_addr;
        end else if (state_q == LOAD && bus.blank) begin
            gnt_c       = 1'b1;
            mem_addr_d  = bus.ld_addr;
            mem_wdata_d = bus.ld_wdata;
            wren_c      = bus.ld_req & ld_in_range_c;
        end
        wr_acc_c = gnt_c & bus.ld_req;

        state_d   = state_q;
        preempt_d = 1'b0;
        case (state_q)
            IDLE: if (bus.ld_req && bus.blank && !bus.disp_req) state_d = LOAD;
            LOAD: begin
                if (!bus.ld_req) begin
                    state_d = IDLE;
                end else if (bus.disp_req || !bus.blank) begin
                    state_d   = IDLE;
                    preempt_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        err_d = err_q | (wr_acc_c & ~ld_in_range_c);

`ifdef SPRITE_ARB_STATS_EN
        wr_cnt_d  = wr_cnt_q;
        pre_cnt_d = pre_cnt_q;
        if (wren_c && wr_cnt_q != 16'hFFFF) wr_cnt_d = wr_cnt_q + 16'd1;
        if (preempt_q && pre_cnt_q != 16'hFFFF) pre_cnt_d = pre_cnt_q + 16'd1;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            preempt_q     <= 1'b0;
            err_q         <= 1'b0;
            rvalid_q      <= 1'b0;
            rd_in_range_q <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
`ifdef SPRITE_ARB_STATS_EN
            wr_cnt_q      <= 16'd0;
            pre_cnt_q     <= 16'd0;
`endif
        end else begin
            state_q       <= state_d;
            preempt_q     <= preempt_d;
            err_q         <= err_d;
            rvalid_q      <= rvalid_d;
            rd_in_range_q <= rd_in_range_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
`ifdef SPRITE_ARB_STATS_EN
            wr_cnt_q      <= wr_cnt_d;
            pre_cnt_q     <= pre_cnt_d;
`endif
        end
    end

    // Combinational port outputs are forced low while reset is asserted.
    assign bus.mem_addr    = rst_n ? mem_addr_d  : '0;
    assign bus.mem_wdata   = rst_n ? mem_wdata_d : '0;
    assign bus.mem_wren    = rst_n & wren_c;
    assign bus.ld_gnt      = rst_n & gnt_c;
    assign bus.ld_preempt  = preempt_q;
    assign bus.ld_err      = err_q;
    assign bus.disp_rvalid = rvalid_q;
    assign bus.disp_rdata  = (rvalid_q && rd_in_range_q) ? bus.mem_rdata : '0;

`ifdef SPRITE_ARB_STATS_EN
    assign wr_count      = wr_cnt_q;
    assign preempt_count = pre_cnt_q;
`endif
endmodule

// File: tb/tb_sprite_mem_arbiter.sv
// tb/tb_sprite_mem_arbiter.sv - directed scoreboard bench for sprite_mem_arbiter
module tb_sprite_mem_arbiter;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    sprite_mem_arbiter_if #(.ADDR_W(16), .DATA_W(8)) bus ();

`ifdef SPRITE_ARB_STATS_EN
    logic [15:0] wr_count, preempt_count;
`endif

    sprite_mem_arbiter #(.ADDR_W(16), .DATA_W(8), .DEPTH(40320)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef SPRITE_ARB_STATS_EN
        ,
        .wr_count      (wr_count),
        .preempt_count (preempt_count)
`endif
    );

    logic [7:0]  sram [0:65535];
    logic        pre_we;
    logic [15:0] pre_addr;
    logic [7:0]  pre_data;

    always @(posedge clk) begin
        if (pre_we) sram[pre_addr] <= pre_data;
        else if (bus.mem_wren) sram[bus.mem_addr] <= bus.mem_wdata;
        bus.mem_rdata <= sram[bus.mem_addr];
    end

    int total = 0;
    int bad = 0;
    int wren_seen;
    logic [7:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic sb_check();
        if (bus.disp_rvalid === 1'b1) begin
            if (exp_q.size() == 0) chk("rvalid_unexpected", 32'd1, 32'd0);
            else chk("disp_rdata", bus.disp_rdata, exp_q.pop_front());
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        sb_check();
    endtask

    task automatic rd(input logic [15:0] a, input logic [7:0] e);
        bus.disp_req  = 1'b1;
        bus.disp_addr = a;
        exp_q.push_back(e);
    endtask

    task automatic preload(input logic [15:0] a, input logic [7:0] d);
        pre_addr = a;
        pre_data = d;
        pre_we   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        pre_we   = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        pre_we = 1'b0; pre_addr = '0; pre_data = '0;
        bus.blank = 1'b0; bus.disp_req = 1'b0; bus.disp_addr = '0;
        bus.ld_req = 1'b0; bus.ld_addr = '0; bus.ld_wdata = '0;

        @(negedge clk); #1;
        chk("rst_rvalid", bus.disp_rvalid, 0);
        chk("rst_gnt", bus.ld_gnt, 0);
        chk("rst_preempt", bus.ld_preempt, 0);
        chk("rst_err", bus.ld_err, 0);
        chk("rst_wren", bus.mem_wren, 0);
        chk("rst_maddr", bus.mem_addr, 0);
        chk("rst_wdata", bus.mem_wdata, 0);

        preload(16'd5, 8'h3C);
        preload(16'd6, 8'hA1);
        for (int i = 20; i < 24; i++) preload(16'(i), 8'hEE);
        preload(16'd40320, 8'h55);
        rst_n = 1'b1;
        #1;
        chk("post_rst_gnt", bus.ld_gnt, 0);

        // Back-to-back display reads
        rd(16'd5, 8'h3C);
        #1 chk("rd_maddr", bus.mem_addr, 5);
        chk("rd_wren", bus.mem_wren, 0);
        step();
        chk("rd_rvalid0", bus.disp_rvalid, 1);
        rd(16'd6, 8'hA1);
        step();
        chk("rd_rvalid1", bus.disp_rvalid, 1);
        bus.disp_req = 1'b0;
        step();
        chk("rd_rvalid_end", bus.disp_rvalid, 0);

        // Four-word loader burst
        bus.blank = 1'b1; bus.ld_req = 1'b1; bus.ld_addr = 16'd0; bus.ld_wdata = 8'h10;
        #1 chk("burst_first_gnt", bus.ld_gnt, 0);
        step();
        wren_seen = 0;
        for (int i = 0; i < 4; i++) begin
            bus.ld_addr  = 16'(i);
            bus.ld_wdata = 8'(8'h10 + i);
            #1 chk("burst_gnt", bus.ld_gnt, 1);
            if (bus.mem_wren === 1'b1) wren_seen++;
            step();
        end
        bus.ld_req = 1'b0;
        #1 chk("burst_end_wren", bus.mem_wren, 0);
        step();
        chk("burst_no_preempt", bus.ld_preempt, 0);
        chk("burst_wren_count", wren_seen, 4);
        for (int i = 0; i < 4; i++) begin
            rd(16'(i), 8'(8'h10 + i));
            step();
        end
        bus.disp_req = 1'b0;
        step();

        // Reset in the middle of a burst
        bus.ld_req = 1'b1; bus.ld_addr = 16'd30; bus.ld_wdata = 8'h77;
        #1 chk("mr_first_gnt", bus.ld_gnt, 0);
        step();
        #1 chk("mr_wren_before", bus.mem_wren, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("mr_wren_async", bus.mem_wren, 0);
        chk("mr_gnt_async", bus.ld_gnt, 0);
        chk("mr_maddr_async", bus.mem_addr, 0);
        chk("mr_wdata_async", bus.mem_wdata, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("mr_no_resume", bus.ld_gnt, 0);
        bus.ld_req = 1'b0;
        step();

        // Preempt by blank falling after two writes
        bus.ld_req = 1'b1; bus.ld_addr = 16'd20; bus.ld_wdata = 8'h50;
        #1 chk("pre_first_gnt", bus.ld_gnt, 0);
        step();
        #1 chk("pre_wren0", bus.mem_wren, 1);
        step();
        bus.ld_addr = 16'd21; bus.ld_wdata = 8'h51;
        #1 chk("pre_wren1", bus.mem_wren, 1);
        step();
        bus.ld_addr = 16'd22; bus.ld_wdata = 8'h52; bus.blank = 1'b0;
        #1 chk("pre_cut_gnt", bus.ld_gnt, 0);
        chk("pre_cut_wren", bus.mem_wren, 0);
        step();
        chk("pre_pulse", bus.ld_preempt, 1);
        step();
        chk("pre_pulse_end", bus.ld_preempt, 0);
        chk("pre_idle_gnt", bus.ld_gnt, 0);
        bus.ld_req = 1'b0; bus.blank = 1'b1;
`ifdef SPRITE_ARB_STATS_EN
        chk("stats_wr", wr_count, 2);
        chk("stats_pre", preempt_count, 1);
`endif
        rd(16'd20, 8'h50); step();
        rd(16'd21, 8'h51); step();
        rd(16'd22, 8'hEE); step();
        rd(16'd23, 8'hEE); step();
        bus.disp_req = 1'b0;
        step();

        // Out-of-range boundary
        chk("err_before", bus.ld_err, 0);
        bus.ld_req = 1'b1; bus.ld_addr = 16'd40320; bus.ld_wdata = 8'h99;
        #1 chk("oor_first_gnt", bus.ld_gnt, 0);
        step();
        #1 chk("oor_gnt", bus.ld_gnt, 1);
        chk("oor_wren", bus.mem_wren, 0);
        step();
        chk("oor_err_set", bus.ld_err, 1);
        bus.ld_addr = 16'd40319; bus.ld_wdata = 8'h42;
        #1 chk("last_word_wren", bus.mem_wren, 1);
        step();
        bus.ld_req = 1'b0;
        step();
        step();
        chk("err_sticky", bus.ld_err, 1);
        rd(16'd40320, 8'h00); step();
        rd(16'd40319, 8'h42); step();
        bus.disp_req = 1'b0;
        step();

        // Display/loader conflict in IDLE, then display preempting LOAD
        bus.ld_req = 1'b1; bus.ld_addr = 16'd50; bus.ld_wdata = 8'h66;
        rd(16'd0, 8'h10);
        #1 chk("cf_gnt0", bus.ld_gnt, 0);
        chk("cf_wren0", bus.mem_wren, 0);
        chk("cf_maddr0", bus.mem_addr, 0);
        step();
        rd(16'd1, 8'h11);
        #1 chk("cf_gnt1", bus.ld_gnt, 0);
        step();
        bus.disp_req = 1'b0;
        #1 chk("cf_stay_idle", bus.ld_gnt, 0);
        step();
        #1 chk("cf_gnt_late", bus.ld_gnt, 1);
        chk("cf_wren_late", bus.mem_wren, 1);
        chk("cf_maddr_late", bus.mem_addr, 50);
        step();
        bus.ld_addr = 16'd51; bus.ld_wdata = 8'h67;
        rd(16'd2, 8'h12);
        #1 chk("dp_gnt", bus.ld_gnt, 0);
        chk("dp_wren", bus.mem_wren, 0);
        chk("dp_maddr", bus.mem_addr, 2);
        step();
        chk("dp_pulse", bus.ld_preempt, 1);
        bus.disp_req = 1'b0; bus.ld_req = 1'b0;
        step();
        rd(16'd50, 8'h66); step();
        bus.disp_req = 1'b0;
        step();
        chk("sb_drained", exp_q.size(), 0);
        chk("err_final", bus.ld_err, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
